// File: rtl/amax10_qsys_irq_arbiter.sv
// amax10_qsys_irq_arbiter
// Falling-edge interrupt capture for up to 16 lines, arbitrated into a single
// CPU interrupt. A granted source is held until firmware acknowledges it by ID
// or until its request disappears.
module amax10_qsys_irq_arbiter #(
    parameter int NUM_SRC     = 8,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    input  logic [NUM_SRC-1:0] in_port,
    output logic               irq
);

    localparam logic [NUM_SRC-1:0] LP_ONE  = NUM_SRC'(1);
    localparam logic [3:0]         LP_LAST = 4'(NUM_SRC - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             r_state;
    logic [NUM_SRC-1:0] r_d1;
    logic [NUM_SRC-1:0] r_d2;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [3:0]         r_grant_id;
    logic [3:0]         r_rr_ptr;
    logic [15:0]        r_count;
    logic               r_irq;
    logic [31:0]        r_readdata;

    logic               w_wr;
    logic               w_rd;
    logic               w_wr_pend;
    logic               w_wr_mask;
    logic               w_wr_ack;
    logic               w_in_grant;
    logic               w_ack_hit;
    logic               w_req_cur;
    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_req;
    logic [NUM_SRC-1:0] w_gnt_oh;
    logic [NUM_SRC-1:0] w_clr;
    logic [3:0]         w_base;
    logic [3:0]         w_winner;
    logic               w_found;
    logic [4:0]         w_idx;
    logic [31:0]        w_rdata;
    logic               w_unused_wdata;

    assign w_edge     = ~r_d1 & r_d2;
    assign w_wr       = chipselect & ~write_n;
    assign w_rd       = chipselect & write_n;
    assign w_wr_pend  = w_wr && (address == 3'd1);
    assign w_wr_mask  = w_wr && (address == 3'd2);
    assign w_wr_ack   = w_wr && (address == 3'd4);
    assign w_req      = r_pending & r_mask;
    assign w_gnt_oh   = LP_ONE << r_grant_id;
    assign w_in_grant = (r_state == S_GRANT);
    assign w_ack_hit  = w_wr_ack && w_in_grant && (writedata[3:0] == r_grant_id);
    assign w_req_cur  = |(w_req & w_gnt_oh);
    // Clears from W1C and from an accepted ACK; a same-cycle edge overrides them.
    assign w_clr      = ({NUM_SRC{w_wr_pend}} & writedata[NUM_SRC-1:0])
                      | ({NUM_SRC{w_ack_hit}} & w_gnt_oh);
    assign w_base     = ROUND_ROBIN ? r_rr_ptr : 4'd0;
    assign w_unused_wdata = ^writedata;

    assign irq      = r_irq;
    assign readdata = r_readdata;

    // Arbiter: first request found searching upward from w_base, wrapping at NUM_SRC.
    always_comb begin
        w_winner = 4'd0;
        w_found  = 1'b0;
        w_idx    = 5'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_idx = 5'(w_base) + 5'(k);
            if (w_idx >= 5'(NUM_SRC)) begin
                w_idx = w_idx - 5'(NUM_SRC);
            end
            if (!w_found && |(w_req & (LP_ONE << w_idx))) begin
                w_found  = 1'b1;
                w_winner = w_idx[3:0];
            end
        end
    end

    // Register read multiplexer; unused addresses and bits read as zero.
    always_comb begin
        w_rdata = 32'd0;
        case (address)
            3'd0:    w_rdata = 32'(r_d1);
            3'd1:    w_rdata = 32'(r_pending);
            3'd2:    w_rdata = 32'(r_mask);
            3'd3:    w_rdata = {w_in_grant, 27'd0, r_grant_id};
            3'd5:    w_rdata = {16'd0, r_count};
            default: w_rdata = 32'd0;
        endcase
    end

    // Two-flop synchroniser; zero reset keeps a line held low through reset silent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d1 <= '0;
            r_d2 <= '0;
        end else begin
            r_d1 <= in_port;
            r_d2 <= r_d1;
        end
    end

    // Pending capture with set-over-clear priority, and the mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (w_wr_mask) begin
                r_mask <= writedata[NUM_SRC-1:0];
            end
        end
    end

    // Grant FSM with registered irq, acknowledge counter and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_grant_id <= 4'd0;
            r_rr_ptr   <= 4'd0;
            r_count    <= 16'd0;
            r_irq      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_state    <= S_GRANT;
                        r_grant_id <= w_winner;
                        r_irq      <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (w_ack_hit) begin
                        r_state  <= S_IDLE;
                        r_irq    <= 1'b0;
                        r_count  <= r_count + 16'd1;
                        r_rr_ptr <= (r_grant_id == LP_LAST) ? 4'd0 : r_grant_id + 4'd1;
                    end else if (!w_req_cur) begin
                        r_state <= S_IDLE;
                        r_irq   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Read data is captured on a read cycle and held otherwise (latency 1).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 32'd0;
        end else if (w_rd) begin
            r_readdata <= w_rdata;
        end
    end

endmodule

// File: tb/tb_amax10_qsys_irq_arbiter.sv
// Directed bench for amax10_qsys_irq_arbiter: one round-robin and one
// fixed-priority instance share the same bus and interrupt lines.
module tb_amax10_qsys_irq_arbiter;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd_rr;
    logic [31:0] rd_fp;
    logic        irq_rr;
    logic        irq_fp;

    int n_checks;
    int n_fail;

    amax10_qsys_irq_arbiter #(.NUM_SRC(8), .ROUND_ROBIN(1'b1)) dut_rr (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd_rr),
        .in_port    (in_port),
        .irq        (irq_rr)
    );

    amax10_qsys_irq_arbiter #(.NUM_SRC(8), .ROUND_ROBIN(1'b0)) dut_fp (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd_fp),
        .in_port    (in_port),
        .irq        (irq_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic read_chk(input string tag, input logic [2:0] a,
                            input logic [31:0] exp_rr, input logic [31:0] exp_fp);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        tick();
        chipselect = 1'b0;
        check_eq({tag, "_rr"}, rd_rr, exp_rr);
        check_eq({tag, "_fp"}, rd_fp, exp_fp);
    endtask

    task automatic irq_chk(input string tag, input logic exp_rr, input logic exp_fp);
        check_eq({tag, "_irq_rr"}, 32'(irq_rr), 32'(exp_rr));
        check_eq({tag, "_irq_fp"}, 32'(irq_fp), 32'(exp_fp));
    endtask

    // Drop the given lines for three clocks (enough for a grant), then release.
    task automatic fall_lines(input logic [7:0] lines);
        in_port = ~lines;
        tick();
        tick();
        tick();
        in_port = 8'hFF;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        in_port    = 8'hFF;
        tick();
        tick();
        tick();
        irq_chk("rst", 1'b0, 1'b0);
        check_eq("rst_rd_rr", rd_rr, 32'd0);
        check_eq("rst_rd_fp", rd_fp, 32'd0);
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        read_chk("rst_status",  3'd0, 32'hFF, 32'hFF);
        read_chk("rst_pending", 3'd1, 32'd0, 32'd0);
        read_chk("rst_mask",    3'd2, 32'd0, 32'd0);
        read_chk("rst_vector",  3'd3, 32'd0, 32'd0);
        read_chk("rst_count",   3'd5, 32'd0, 32'd0);
        read_chk("rst_unused",  3'd6, 32'd0, 32'd0);

        // Single source on line 0
        bus_write(3'd2, 32'h01);
        in_port = 8'hFE;
        tick();
        tick();
        irq_chk("t1_early", 1'b0, 1'b0);
        tick();
        irq_chk("t1_rise", 1'b1, 1'b1);
        in_port = 8'hFF;
        read_chk("t1_pending", 3'd1, 32'h01, 32'h01);
        read_chk("t1_vector",  3'd3, 32'h8000_0000, 32'h8000_0000);
        bus_write(3'd4, 32'd0);
        irq_chk("t1_ack", 1'b0, 1'b0);
        read_chk("t1_pend_clr", 3'd1, 32'd0, 32'd0);
        read_chk("t1_count",    3'd5, 32'd1, 32'd1);

        // Round robin: lines 2 and 5 together, twice
        bus_write(3'd2, 32'hFF);
        for (int r = 0; r < 2; r++) begin
            fall_lines(8'h24);
            read_chk("rr_vec2", 3'd3, 32'h8000_0002, 32'h8000_0002);
            bus_write(3'd4, 32'd2);
            irq_chk("rr_gap", 1'b0, 1'b0);
            tick();
            irq_chk("rr_next", 1'b1, 1'b1);
            read_chk("rr_vec5", 3'd3, 32'h8000_0005, 32'h8000_0005);
            bus_write(3'd4, 32'd5);
            irq_chk("rr_done", 1'b0, 1'b0);
        end
        read_chk("rr_count", 3'd5, 32'd5, 32'd5);

        // Lines 0 and 7 with rr_ptr=6: round robin picks 7, fixed picks 0
        fall_lines(8'h81);
        read_chk("div_vec_a", 3'd3, 32'h8000_0007, 32'h8000_0000);
        bus_write(3'd4, 32'd7);
        irq_chk("div_ack7", 1'b0, 1'b1);
        tick();
        read_chk("div_vec_b", 3'd3, 32'h8000_0000, 32'h8000_0000);
        bus_write(3'd4, 32'd0);
        irq_chk("div_ack0", 1'b0, 1'b0);
        tick();
        read_chk("div_vec_c", 3'd3, 32'h0000_0000, 32'h8000_0007);
        bus_write(3'd4, 32'd7);
        irq_chk("div_end", 1'b0, 1'b0);
        read_chk("div_count", 3'd5, 32'd7, 32'd7);

        // Masking
        bus_write(3'd2, 32'h00);
        fall_lines(8'h08);
        irq_chk("msk_off", 1'b0, 1'b0);
        read_chk("msk_pending", 3'd1, 32'h08, 32'h08);
        bus_write(3'd2, 32'h08);
        irq_chk("msk_wr", 1'b0, 1'b0);
        tick();
        irq_chk("msk_on", 1'b1, 1'b1);
        read_chk("msk_vector", 3'd3, 32'h8000_0003, 32'h8000_0003);
        bus_write(3'd4, 32'd3);
        read_chk("msk_count", 3'd5, 32'd8, 32'd8);

        // Wrong ACK, revoke by W1C, ACK while idle
        bus_write(3'd2, 32'h10);
        fall_lines(8'h10);
        irq_chk("ign_grant", 1'b1, 1'b1);
        bus_write(3'd4, 32'd1);
        irq_chk("ign_wrong", 1'b1, 1'b1);
        read_chk("ign_count", 3'd5, 32'd8, 32'd8);
        read_chk("ign_vector", 3'd3, 32'h8000_0004, 32'h8000_0004);
        bus_write(3'd1, 32'h10);
        tick();
        irq_chk("rvk", 1'b0, 1'b0);
        read_chk("rvk_count",   3'd5, 32'd8, 32'd8);
        read_chk("rvk_pending", 3'd1, 32'd0, 32'd0);
        read_chk("rvk_vector",  3'd3, 32'h4, 32'h4);
        bus_write(3'd4, 32'd4);
        tick();
        irq_chk("idle_ack", 1'b0, 1'b0);
        read_chk("idle_count", 3'd5, 32'd8, 32'd8);

        // Collision: edge on line 4 in the same cycle as its ACK
        fall_lines(8'h10);
        read_chk("col_vec_a", 3'd3, 32'h8000_0004, 32'h8000_0004);
        in_port = 8'hEF;
        tick();
        bus_write(3'd4, 32'd4);
        in_port = 8'hFF;
        irq_chk("col_ack", 1'b0, 1'b0);
        tick();
        irq_chk("col_regrant", 1'b1, 1'b1);
        read_chk("col_pending", 3'd1, 32'h10, 32'h10);
        read_chk("col_vec_b",   3'd3, 32'h8000_0004, 32'h8000_0004);
        read_chk("col_count",   3'd5, 32'd9, 32'd9);

        // Reset mid-grant with line 4 held low through release
        in_port = 8'hEF;
        tick();
        reset_n = 1'b0;
        #1;
        irq_chk("mrst_irq", 1'b0, 1'b0);
        check_eq("mrst_rd_rr", rd_rr, 32'd0);
        check_eq("mrst_rd_fp", rd_fp, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        tick();
        irq_chk("mrst_rel", 1'b0, 1'b0);
        read_chk("mrst_pending", 3'd1, 32'd0, 32'd0);
        read_chk("mrst_mask",    3'd2, 32'd0, 32'd0);
        read_chk("mrst_vector",  3'd3, 32'd0, 32'd0);
        read_chk("mrst_count",   3'd5, 32'd0, 32'd0);
        read_chk("mrst_status",  3'd0, 32'hEF, 32'hEF);
        in_port = 8'hFF;
        tick();
        tick();

        // COUNT wrap: preload 0xFFFE, then two acknowledged grants
        bus_write(3'd2, 32'h10);
        force dut_rr.r_count = 16'hFFFE;
        force dut_fp.r_count = 16'hFFFE;
        #1;
        release dut_rr.r_count;
        release dut_fp.r_count;
        fall_lines(8'h10);
        bus_write(3'd4, 32'd4);
        read_chk("wrap_ffff", 3'd5, 32'hFFFF, 32'hFFFF);
        tick();
        fall_lines(8'h10);
        irq_chk("wrap_grant", 1'b1, 1'b1);
        bus_write(3'd4, 32'd4);
        read_chk("wrap_zero", 3'd5, 32'h0000, 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/amax10_qsys_irq_arbiter.md
# amax10_qsys_irq_arbiter

Avalon-MM slave interrupt controller that captures falling edges on up to 16 input lines and arbitrates them into one CPU interrupt. Each pending, unmasked source is granted in turn and held until firmware acknowledges it by ID. The block sits between the gesture/light-sensor interrupt lines and the Nios II IRQ input in the amax10_qsys system. It replaces per-line edge-capture cores when more than one sensor line must be serviced in a defined order.

## Interface
- NUM_SRC, 8, number of interrupt inputs; legal range 1..16.
- ROUND_ROBIN, 1, selects the arbitration scheme: 1 = round-robin, 0 = fixed priority (lowest index wins).

- clk  input  1  system clock; single clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  3  register word select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  registered read data; reset value 0.
- in_port  input  NUM_SRC  asynchronous interrupt lines; a falling edge is an event.
- irq  output  1  registered; high while a grant is outstanding; reset value 0.

## Operation
- **Synchroniser.** Each line passes through two flops, d1 then d2, both reset to 0.
- **Edge detect.** edge[i] = ~d1[i] & d2[i].
- **Register map.** Reads return 0 in unused bits; unused addresses read 0 and ignore writes.
  - 0 STATUS (RO): d1 values.
  - 1 PENDING (R/W1C): pending[i] is set by edge[i]. Writing 1 clears the bit.
  - 2 MASK (RW): mask[NUM_SRC-1:0], reset 0.
  - 3 VECTOR (RO): bit 31 = grant valid (state GRANT); bits [3:0] = grant_id. Reads have no side effects.
  - 4 ACK (WO): bits [3:0] = ID being acknowledged.
  - 5 COUNT (RO): 16-bit count of acknowledged grants; wraps 0xFFFF to 0x0000.
- **Set/clear priority.** A set from edge[i] wins over a clear of bit i (W1C or ACK) in the same cycle; the bit stays 1.
- **Request vector.** req = pending & mask.
- **State machine.** The FSM has two states, IDLE and GRANT; reset state is IDLE.
  - IDLE: if req is non-zero, latch grant_id = the arbiter winner and go to GRANT.
  - GRANT, accepted ACK: an ACK write with ID equal to grant_id clears pending[grant_id], increments COUNT, loads rr_ptr = grant_id+1 (mod NUM_SRC) and returns to IDLE.
  - GRANT, revoke: if req[grant_id] goes to 0 (W1C or mask cleared) with no matching ACK in that cycle, return to IDLE. COUNT and rr_ptr are unchanged.
  - GRANT, ignored writes: an ACK whose ID does not match grant_id is ignored and the FSM stays in GRANT.
  - GRANT, no re-arbitration: other sources becoming pending do not change grant_id.
  - IDLE: ACK writes are ignored.
- **Arbitration.**
  - ROUND_ROBIN=1: the first set req bit found by searching upward from rr_ptr, wrapping at NUM_SRC. rr_ptr resets to 0.
  - ROUND_ROBIN=0: the lowest set index; rr_ptr is unused.
- **irq.** Registered; irq = 1 exactly in the cycles where the FSM is in GRANT.
- **Reset.** Asserting reset_n at any time, including mid-grant, forces IDLE and clears irq, pending, mask, COUNT, rr_ptr, grant_id, d1, d2 and readdata.
- **Reset-release events.** A line held low through reset release produces no event, because d2 resets to 0.

## Timing
- readdata is valid one clock after a read cycle (chipselect=1, write_n=1), matching a read latency of 1.
- Edge to irq latency, with clock edge k being the one at which d1 first samples 0:
  - edge[i] is high after edge k;
  - pending[i] = 1 after edge k+1;
  - state = GRANT and irq = 1 after edge k+2.
- Writes take effect on the clock edge on which the write is presented.
- Matching ACK at edge m: irq = 0 and state = IDLE after edge m. If another req remains, GRANT and irq = 1 follow after edge m+1, giving a minimum one-cycle irq low gap between grants.
- Revoke: irq falls one clock after req[grant_id] falls.
- A pulse narrower than one clock may be missed; the minimum detectable low time is 1 clock.

## Test plan
- **Single source.** NUM_SRC=8, MASK=0x01, fall in_port[0] → PENDING reads 0x01; irq rises 3 clocks after the in_port fall; VECTOR=0x80000000. Then ACK=0 → irq=0 next clock, PENDING=0, COUNT=1.
- **Round-robin.** MASK=0xFF; fall lines 2 and 5 in the same cycle → grants in order 2, then 5. Then pend lines 2 and 5 again with rr_ptr=6 → grant 2 first, after wrapping. With ROUND_ROBIN=0, the same stimulus grants 2 then 5 on every round.
- **Masking.** MASK=0x00 and fall line 3 → PENDING=0x08 and irq stays 0. Then write MASK=0x08 → irq=1 two clocks later.
- **Ignored writes.**
  - Wrong ACK: in GRANT with id 4, ACK=1 → irq stays 1, COUNT unchanged.
  - Idle ACK: ACK written in IDLE → no effect.
- **Collision and revoke.**
  - Collision: an edge on line 4 in the same cycle as a matching ACK of 4 → PENDING bit 4 stays 1 and a new grant of 4 follows.
  - Revoke: W1C of PENDING=0x10 while grant_id is 4 → irq=0 next clock, COUNT unchanged.
- **Reset and wrap.**
  - Reset mid-grant: assert reset_n=0 while in GRANT → irq, readdata and all registers read 0 after release; no spurious event if in_port is held low.
  - COUNT wrap: preload via 65536 ACKs → COUNT reads 0x0000.
